// File: rtl/decode_ea_sequencer.sv
// Effective-address byte sequencer: parses ModR/M, optional SIB and displacement
// bytes from the prefetch stream and hands one decoded EA record to address generation.
module decode_ea_sequencer #(
   parameter int DISP_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  busy,
   output logic                  ea_valid,
   input  logic                  ea_ready,
   output logic [1:0]            ea_mod,
   output logic [2:0]            ea_reg,
   output logic [2:0]            ea_rm,
   output logic                  ea_sib_present,
   output logic [1:0]            ea_scale,
   output logic                  ea_index_used,
   output logic [2:0]            ea_index,
   output logic                  ea_base_used,
   output logic [2:0]            ea_base,
   output logic [DISP_WIDTH-1:0] ea_disp,
   output logic [2:0]            ea_disp_bytes,
   output logic                  ea_undefined
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MODRM = 3'd1;
   localparam logic [2:0] S_SIB   = 3'd2;
   localparam logic [2:0] S_DISP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]            state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic [1:0]            mod_q, mod_d;
   logic [2:0]            reg_q, reg_d;
   logic [2:0]            rm_q, rm_d;
   logic                  sib_present_q, sib_present_d;
   logic [1:0]            scale_q, scale_d;
   logic                  index_used_q, index_used_d;
   logic [2:0]            index_q, index_d;
   logic                  base_used_q, base_used_d;
   logic [2:0]            base_q, base_d;
   logic [DISP_WIDTH-1:0] disp_q, disp_d;
   logic [2:0]            disp_bytes_q, disp_bytes_d;
   logic                  undefined_q, undefined_d;
   logic                  hs;
   logic                  clear_rec;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mod_d         = mod_q;
      reg_d         = reg_q;
      rm_d          = rm_q;
      sib_present_d = sib_present_q;
      scale_d       = scale_q;
      index_used_d  = index_used_q;
      index_d       = index_q;
      base_used_d   = base_used_q;
      base_d        = base_q;
      disp_d        = disp_q;
      disp_bytes_d  = disp_bytes_q;
      undefined_d   = undefined_q;
      clear_rec     = 1'b0;
      byte_ready    = ((state_q == S_MODRM) || (state_q == S_SIB) || (state_q == S_DISP)) && !abort;
      hs            = byte_valid && byte_ready;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_MODRM;
               clear_rec = 1'b1;
            end
         end
         S_MODRM: begin
            if (hs) begin
               mod_d       = byte_data[7:6];
               reg_d       = byte_data[5:3];
               rm_d        = byte_data[2:0];
               base_d      = byte_data[2:0];
               base_used_d = 1'b1;
               if (byte_data[7:6] == 2'b11) begin
                  base_used_d = 1'b0;
                  state_d     = S_DONE;
               end else if (byte_data[2:0] == 3'b100) begin
                  state_d = S_SIB;
               end else if (byte_data[7:6] == 2'b00 && byte_data[2:0] == 3'b101) begin
                  // disp32-only addressing: no base register
                  base_used_d  = 1'b0;
                  disp_bytes_d = 3'd4;
                  state_d      = S_DISP;
               end else if (byte_data[7:6] == 2'b01) begin
                  disp_bytes_d = 3'd1;
                  state_d      = S_DISP;
               end else if (byte_data[7:6] == 2'b10) begin
                  disp_bytes_d = 3'd4;
                  state_d      = S_DISP;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_SIB: begin
            if (hs) begin
               sib_present_d = 1'b1;
               scale_d       = byte_data[7:6];
               index_d       = byte_data[5:3];
               base_d        = byte_data[2:0];
               index_used_d  = (byte_data[5:3] != 3'b100);
               undefined_d   = (byte_data[5:3] == 3'b100) && (byte_data[7:6] != 2'b00);
               base_used_d   = 1'b1;
               case (mod_q)
                  2'b00: begin
                     if (byte_data[2:0] == 3'b101) begin
                        base_used_d  = 1'b0;
                        disp_bytes_d = 3'd4;
                        state_d      = S_DISP;
                     end else begin
                        state_d = S_DONE;
                     end
                  end
                  2'b01: begin
                     disp_bytes_d = 3'd1;
                     state_d      = S_DISP;
                  end
                  default: begin
                     disp_bytes_d = 3'd4;
                     state_d      = S_DISP;
                  end
               endcase
            end
         end
         S_DISP: begin
            if (hs) begin
               if (disp_bytes_q == 3'd1)
                  disp_d = {{(DISP_WIDTH-8){byte_data[7]}}, byte_data};
               else
                  disp_d[{cnt_q[1:0], 3'b000} +: 8] = byte_data;
               cnt_d = cnt_q + 3'd1;
               if (cnt_d == disp_bytes_q)
                  state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (ea_ready) begin
               if (start) begin
                  state_d   = S_MODRM;
                  clear_rec = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // flush wins over everything, including a record being accepted
      if (abort) begin
         state_d   = S_IDLE;
         clear_rec = 1'b1;
      end

      if (clear_rec) begin
         cnt_d         = 3'd0;
         mod_d         = 2'd0;
         reg_d         = 3'd0;
         rm_d          = 3'd0;
         sib_present_d = 1'b0;
         scale_d       = 2'd0;
         index_used_d  = 1'b0;
         index_d       = 3'd0;
         base_used_d   = 1'b0;
         base_d        = 3'd0;
         disp_d        = '0;
         disp_bytes_d  = 3'd0;
         undefined_d   = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= 3'd0;
         mod_q         <= 2'd0;
         reg_q         <= 3'd0;
         rm_q          <= 3'd0;
         sib_present_q <= 1'b0;
         scale_q       <= 2'd0;
         index_used_q  <= 1'b0;
         index_q       <= 3'd0;
         base_used_q   <= 1'b0;
         base_q        <= 3'd0;
         disp_q        <= '0;
         disp_bytes_q  <= 3'd0;
         undefined_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mod_q         <= mod_d;
         reg_q         <= reg_d;
         rm_q          <= rm_d;
         sib_present_q <= sib_present_d;
         scale_q       <= scale_d;
         index_used_q  <= index_used_d;
         index_q       <= index_d;
         base_used_q   <= base_used_d;
         base_q        <= base_d;
         disp_q        <= disp_d;
         disp_bytes_q  <= disp_bytes_d;
         undefined_q   <= undefined_d;
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign ea_valid       = (state_q == S_DONE);
   assign ea_mod         = mod_q;
   assign ea_reg         = reg_q;
   assign ea_rm          = rm_q;
   assign ea_sib_present = sib_present_q;
   assign ea_scale       = scale_q;
   assign ea_index_used  = index_used_q;
   assign ea_index       = index_q;
   assign ea_base_used   = base_used_q;
   assign ea_base        = base_q;
   assign ea_disp        = disp_q;
   assign ea_disp_bytes  = disp_bytes_q;
   assign ea_undefined   = undefined_q;

endmodule

// File: tb/tb_decode_ea_sequencer.sv
// Bench for decode_ea_sequencer: directed address-mode vectors, stalls, hold and
// back-to-back, abort/reset flushes, and randomized streams against a record model.
module tb_decode_ea_sequencer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        busy;
   logic        ea_valid;
   logic        ea_ready = 1'b0;
   logic [1:0]  ea_mod;
   logic [2:0]  ea_reg;
   logic [2:0]  ea_rm;
   logic        ea_sib_present;
   logic [1:0]  ea_scale;
   logic        ea_index_used;
   logic [2:0]  ea_index;
   logic        ea_base_used;
   logic [2:0]  ea_base;
   logic [31:0] ea_disp;
   logic [2:0]  ea_disp_bytes;
   logic        ea_undefined;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct packed {
      logic        v;
      logic [1:0]  mod;
      logic [2:0]  rg;
      logic [2:0]  rm;
      logic        sib;
      logic [1:0]  ss;
      logic        iu;
      logic [2:0]  idx;
      logic        bu;
      logic [2:0]  base;
      logic [31:0] disp;
      logic [2:0]  dbytes;
      logic        undef;
      logic [3:0]  len;
   } rec_t;

   decode_ea_sequencer #(.DISP_WIDTH(32)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .abort(abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .busy(busy), .ea_valid(ea_valid), .ea_ready(ea_ready),
      .ea_mod(ea_mod), .ea_reg(ea_reg), .ea_rm(ea_rm),
      .ea_sib_present(ea_sib_present), .ea_scale(ea_scale),
      .ea_index_used(ea_index_used), .ea_index(ea_index),
      .ea_base_used(ea_base_used), .ea_base(ea_base), .ea_disp(ea_disp),
      .ea_disp_bytes(ea_disp_bytes), .ea_undefined(ea_undefined)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   // Reference: decode a byte stream from the 32-bit addressing rules directly.
   function automatic rec_t model(input logic [7:0] s [8]);
      rec_t r;
      int   p, nd;
      r      = '0;
      r.v    = 1'b1;
      r.mod  = s[0][7:6];
      r.rg   = s[0][5:3];
      r.rm   = s[0][2:0];
      r.base = s[0][2:0];
      p      = 1;
      if (r.mod != 2'd3 && r.rm == 3'd4) begin
         r.sib   = 1'b1;
         r.ss    = s[1][7:6];
         r.idx   = s[1][5:3];
         r.base  = s[1][2:0];
         r.iu    = (r.idx != 3'd4);
         r.undef = (r.idx == 3'd4) && (r.ss != 2'd0);
         p       = 2;
      end
      case (r.mod)
         2'd0:    nd = (r.base == 3'd5) ? 4 : 0;
         2'd1:    nd = 1;
         2'd2:    nd = 4;
         default: nd = 0;
      endcase
      r.bu   = (r.mod != 2'd3) && !(r.mod == 2'd0 && r.base == 3'd5);
      r.disp = 32'd0;
      for (int k = 0; k < nd; k++)
         r.disp = r.disp + (32'(s[p+k]) << (8*k));
      if (nd == 1)
         r.disp = 32'($signed(s[p]));
      r.dbytes = 3'(nd);
      r.len    = 4'(p + nd);
      return r;
   endfunction

   function automatic rec_t capture(input int consumed);
      rec_t r;
      r = '{v: ea_valid, mod: ea_mod, rg: ea_reg, rm: ea_rm, sib: ea_sib_present,
            ss: ea_scale, iu: ea_index_used, idx: ea_index, bu: ea_base_used,
            base: ea_base, disp: ea_disp, dbytes: ea_disp_bytes, undef: ea_undefined,
            len: 4'(consumed)};
      return r;
   endfunction

   function automatic logic [57:0] all_outs();
      return {byte_ready, busy, ea_valid, ea_mod, ea_reg, ea_rm, ea_sib_present,
              ea_scale, ea_index_used, ea_index, ea_base_used, ea_base, ea_disp,
              ea_disp_bytes, ea_undefined};
   endfunction

   // Pulse start, then offer stream bytes until a record appears (bounded).
   task automatic run_parse(input logic [7:0] s [8], input int gap, input bit rnd, output rec_t obs);
      int idx, guard;
      @(negedge clock); start = 1'b1; byte_valid = 1'b0;
      @(negedge clock); start = 1'b0;
      idx = 0; guard = 0;
      while (ea_valid !== 1'b1 && guard < 300) begin
         if (rnd) byte_valid = ($urandom_range(0, 2) != 0);
         else     byte_valid = ((guard % (gap + 1)) == 0);
         byte_data = (idx < 8) ? s[idx] : 8'h00;
         #1;
         if (byte_valid && byte_ready) idx++;
         @(negedge clock);
         guard++;
      end
      byte_valid = 1'b0;
      obs = capture(idx);
   endtask

   task automatic accept();
      @(negedge clock); ea_ready = 1'b1;
      @(negedge clock); ea_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      n_tests++;
      if (all_outs() !== 58'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h, required 0", all_outs());
      end
      reset_n = 1'b1;
      @(negedge clock);
      n_tests++;
      if (busy !== 1'b0 || byte_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b byte_ready=%b, required 0 0", busy, byte_ready);
      end
   endtask

   task automatic test_directed();
      logic [7:0]  vec [4][8];
      logic [31:0] exp_disp [4];
      int          exp_len [4];
      int          gaps [4];
      logic [7:0]  s [8];
      rec_t        obs, exp;
      vec[0] = '{8'h44, 8'h24, 8'h08, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99};
      vec[1] = '{8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'h99, 8'h99, 8'h99};
      vec[2] = '{8'h04, 8'hE5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h99, 8'h99};
      vec[3] = '{8'h45, 8'hF0, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99};
      exp_disp = '{32'h00000008, 32'h12345678, 32'hDEADBEEF, 32'hFFFFFFF0};
      exp_len  = '{3, 5, 6, 2};
      gaps     = '{0, 0, 0, 3};
      for (int t = 0; t < 4; t++) begin
         s   = vec[t];
         exp = model(s);
         run_parse(s, gaps[t], 1'b0, obs);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL directed_record[%0d]: got %h, required %h", t, obs, exp);
         end
         n_tests++;
         if (obs.disp !== exp_disp[t] || obs.len !== 4'(exp_len[t])) begin
            n_fail++;
            $display("FAIL directed_disp[%0d]: got disp=%h len=%0d, required disp=%h len=%0d",
                     t, obs.disp, obs.len, exp_disp[t], exp_len[t]);
         end
         n_tests++;
         if (byte_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL directed_ready_in_done[%0d]: got %b, required 0", t, byte_ready);
         end
         accept();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] s [8];
      rec_t       exp, obs;
      s   = '{8'hC1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp = model(s);
      @(negedge clock); start = 1'b1; byte_valid = 1'b1; byte_data = 8'hC1;
      @(negedge clock); start = 1'b0;
      n_tests++;
      if (ea_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_early: ea_valid=%b one cycle after start, required 0", ea_valid);
      end
      @(negedge clock); byte_valid = 1'b0;
      n_tests++;
      if (ea_valid !== 1'b1 || byte_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL latency_modrm_only: ea_valid=%b byte_ready=%b, required 1 0", ea_valid, byte_ready);
      end
      for (int c = 0; c < 5; c++) begin
         obs = capture(1);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL hold_stable[%0d]: got %h, required %h", c, obs, exp);
         end
         @(negedge clock);
      end
      ea_ready = 1'b1; start = 1'b1;
      @(negedge clock); ea_ready = 1'b0; start = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || ea_valid !== 1'b0 || byte_ready !== 1'b1 || {ea_mod, ea_rm, ea_disp} !== 37'd0) begin
         n_fail++;
         $display("FAIL b2b_modrm: busy=%b valid=%b ready=%b mod=%0d rm=%0d, required 1 0 1 0 0",
                  busy, ea_valid, byte_ready, ea_mod, ea_rm);
      end
      byte_valid = 1'b1; byte_data = 8'hD8;
      @(negedge clock); byte_valid = 1'b0;
      n_tests++;
      if (ea_valid !== 1'b1 || ea_reg !== 3'd3 || ea_mod !== 2'd3 || ea_rm !== 3'd0) begin
         n_fail++;
         $display("FAIL b2b_record: valid=%b reg=%0d mod=%0d rm=%0d, required 1 3 3 0",
                  ea_valid, ea_reg, ea_mod, ea_rm);
      end
      accept();
   endtask

   task automatic test_abort();
      logic [7:0] s [8];
      rec_t       obs, exp;
      int         hs;
      logic       seen;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0;
      hs = 0;
      for (int i = 0; i < 20 && hs < 3; i++) begin
         byte_valid = 1'b1;
         byte_data  = (hs == 0) ? 8'h05 : (hs == 1) ? 8'h78 : 8'h56;
         #1;
         if (byte_ready) hs++;
         @(negedge clock);
      end
      abort = 1'b1; byte_valid = 1'b1; byte_data = 8'h34;
      #1;
      n_tests++;
      if (byte_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_ready: got %b, required 0", byte_ready);
      end
      @(negedge clock); abort = 1'b0; byte_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b0 || ea_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", busy, ea_valid);
      end
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (ea_valid !== 1'b0) seen = 1'b1;
         @(negedge clock);
      end
      n_tests++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_valid: got ea_valid asserted, required never");
      end
      s   = '{8'h44, 8'h24, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      exp = model(s);
      run_parse(s, 0, 1'b0, obs);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL abort_reparse: got %h, required %h", obs, exp);
      end
      accept();
   endtask

   task automatic test_reset_mid_parse();
      logic [7:0] s [8];
      rec_t       obs, exp;
      @(negedge clock); start = 1'b1;
      @(negedge clock); start = 1'b0; byte_valid = 1'b1; byte_data = 8'h05;
      @(negedge clock); byte_data = 8'h78;
      @(negedge clock); byte_valid = 1'b0;
      n_tests++;
      if (busy !== 1'b1 || ea_disp[7:0] !== 8'h78) begin
         n_fail++;
         $display("FAIL mid_disp_state: busy=%b disp=%h, required 1 xxxxxx78", busy, ea_disp);
      end
      #2 reset_n = 1'b0;
      #1;
      n_tests++;
      if (all_outs() !== 58'd0) begin
         n_fail++;
         $display("FAIL async_reset_outputs: got %h, required 0", all_outs());
      end
      @(negedge clock); reset_n = 1'b1;
      s   = '{8'h05, 8'h78, 8'h56, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00};
      exp = model(s);
      run_parse(s, 1, 1'b0, obs);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL reset_reparse: got %h, required %h", obs, exp);
      end
      accept();
   endtask

   task automatic test_random();
      logic [7:0] s [8];
      rec_t       obs, exp;
      for (int it = 0; it < 60; it++) begin
         for (int k = 0; k < 8; k++) s[k] = 8'($urandom);
         exp = model(s);
         run_parse(s, 0, 1'b1, obs);
         n_tests++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL random_record[%0d] modrm=%h sib=%h: got %h, required %h", it, s[0], s[1], obs, exp);
         end
         accept();
         n_tests++;
         if (ea_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL random_accept[%0d]: valid=%b busy=%b, required 0 0", it, ea_valid, busy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_abort();
      test_reset_mid_parse();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
